muldiv_unit: RTL

Multi-cycle integer multiply/divide engine in the EX stage. It executes the MULT, MULTU, DIV and DIVU operations that the ALU decoder selects, and produces the 64-bit {HI,LO} result.
- The pipeline drives start_i/op_i and holds the EX stage while busy_o is high.
- ready_o marks the single cycle in which hi_o/lo_o carry a fresh result to be written into HI/LO.
- flush_i, from exception handling, cancels an operation in flight.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// EX-stage request/result bundle between the pipeline and the multiply/divide engine.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic             flush_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  busy_o, ready_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output busy_o, ready_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up applied when the result is committed.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q;
  logic               neg_p_q;
  logic               neg_r_q;
  logic               bzero_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mag_d;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               busy_q;
  logic               ready_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_in;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Unsigned magnitudes; 0x80000000 maps to 2^31, still representable unsigned.
  always_comb begin
    signed_in = ~bus.op_i[0];
    abs_a     = (signed_in && bus.src_a_i[WIDTH-1]) ? ('0 - bus.src_a_i) : bus.src_a_i;
    abs_b     = (signed_in && bus.src_b_i[WIDTH-1]) ? ('0 - bus.src_b_i) : bus.src_b_i;
  end

  // acc_hi: running high product / partial remainder; acc_lo: multiplier / dividend->quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_d : '0)};
    div_ge   = ({acc_hi, acc_lo[WIDTH-1]} >= {1'b0, mag_d});
    div_diff = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} - mag_d;
    nxt_hi   = mul_sum[WIDTH:1];
    nxt_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div_q) begin
      nxt_hi = div_ge ? div_diff : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    prod_fix = neg_p_q ? ('0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    quo_fix  = neg_p_q ? ('0 - acc_lo) : acc_lo;
    rem_fix  = neg_r_q ? ('0 - acc_hi) : acc_hi;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      res_hi = bzero_q ? a_q : rem_fix;
      res_lo = bzero_q ? '1  : quo_fix;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
      mag_d    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      // A flush in DONE still commits: the result is architecturally final there.
      if (bus.flush_i && state != DONE) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start_i) begin
              state    <= RUN;
              busy_q   <= 1'b1;
              cnt      <= '0;
              is_div_q <= bus.op_i[1];
              neg_p_q  <= signed_in & (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]);
              neg_r_q  <= signed_in & bus.src_a_i[WIDTH-1];
              bzero_q  <= (bus.src_b_i == '0);
              a_q      <= bus.src_a_i;
              mag_d    <= bus.op_i[1] ? abs_b : abs_a;
              acc_lo   <= bus.op_i[1] ? abs_a : abs_b;
              acc_hi   <= '0;
            end
          end
          RUN: begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
            end
          end
          DONE: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.ready_o = ready_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule
